seg_scan_encoder: RTL



---
 rtl/seg_scan_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg_scan_encoder.sv
// Seven-segment scan encoder: recovers digit values from a multiplexed display bus
// and emits whole frames on a valid/ready port. Define SEG_HEX_EN to accept glyphs A-F.
module seg_scan_encoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_err
);

  localparam int         IDX_W    = $clog2(DIGITS);
  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] STAB_CAP = 4'(STABLE_CYCLES - 2);

  logic [DIGITS-1:0]   prev_sel;
  logic [6:0]          prev_seg;
  logic [3:0]          stab_cnt;
  logic [3:0]          slot [DIGITS];
  logic [DIGITS-1:0]   slot_err;
  logic [DIGITS-1:0]   captured;
  logic [4*DIGITS-1:0] slot_flat;

  logic              legal;
  logic              same;
  logic              capture;
  logic              xfer;
  logic [IDX_W-1:0]  sel_idx;
  logic [4:0]        decoded;

  // Result is {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = 5'h00;
      7'h06:   res = 5'h01;
      7'h5B:   res = 5'h02;
      7'h4F:   res = 5'h03;
      7'h66:   res = 5'h04;
      7'h6D:   res = 5'h05;
      7'h7D:   res = 5'h06;
      7'h07:   res = 5'h07;
      7'h7F:   res = 5'h08;
      7'h6F:   res = 5'h09;
`ifdef SEG_HEX_EN
      7'h77:   res = 5'h0A;
      7'h7C:   res = 5'h0B;
      7'h39:   res = 5'h0C;
      7'h5E:   res = 5'h0D;
      7'h79:   res = 5'h0E;
      7'h71:   res = 5'h0F;
`endif
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  always_comb begin
    legal   = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    same    = (dig_sel == prev_sel) && (seg_in == prev_seg);
    decoded = decode_seg(seg_in);
    if (STABLE_CYCLES == 1) capture = legal;
    else                    capture = legal && same && (stab_cnt == STAB_CAP);
    xfer    = (&captured) && (!frame_valid || frame_ready);
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (dig_sel[i]) sel_idx = IDX_W'(i);
  end

  always_comb begin
    slot_flat = '0;
    for (int i = 0; i < DIGITS; i++)
      slot_flat[4*i +: 4] = slot[i];
  end

  // Stability tracking; the counter saturates so each stable run captures only once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_sel <= '0;
      prev_seg <= '0;
      stab_cnt <= '0;
    end else begin
      prev_sel <= dig_sel;
      prev_seg <= seg_in;
      if (!legal || !same)        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 4'd1;
    end
  end

  // The capture assignment follows the transfer clear so a same-cycle capture keeps its bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      captured <= '0;
      slot_err <= '0;
      for (int i = 0; i < DIGITS; i++) slot[i] <= '0;
    end else begin
      if (xfer) captured <= '0;
      if (capture) begin
        captured[sel_idx] <= 1'b1;
        slot[sel_idx]     <= decoded[3:0];
        slot_err[sel_idx] <= decoded[4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      digit_err   <= '0;
      frame_err   <= 1'b0;
    end else if (xfer) begin
      frame_valid <= 1'b1;
      frame_data  <= slot_flat;
      digit_err   <= slot_err;
      frame_err   <= |slot_err;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule
